// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid buffer used as a pipeline stage register.
//
// The main register always drives the downstream side. The skid register
// holds one extra payload, which lets in_ready be a plain flop with no
// combinational path from out_ready.
//
// Ports:
//   clock      rising-edge clock for all state
//   reset      synchronous, active-high reset
//   flush      discard every held entry at the next edge
//   in_valid   upstream presents a payload
//   in_data    upstream payload (DATA_WIDTH bits)
//   in_ready   stage can accept a payload this cycle (registered)
//   out_valid  downstream payload is valid
//   out_data   downstream payload, BUBBLE_VALUE when empty
//   out_ready  downstream accepts the payload this cycle
//   count      number of held entries (0, 1 or 2)
module pipe_stage_reg #(
  parameter int                    DATA_WIDTH   = 64,
  parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [1:0]            count
);

  // The state encoding is the entry count, so count is the state register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  in_ready_q, in_ready_d;
  logic                  in_xfer;
  logic                  out_xfer;

  always_comb begin
    in_xfer    = in_valid & in_ready_q;
    out_xfer   = (state_q != EMPTY) & out_ready;
    state_d    = state_q;
    main_d     = main_q;
    skid_d     = skid_q;

    // Flush beats any transfer; an output transfer in this cycle has already
    // been seen by the downstream stage, so nothing else is needed for it.
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE_VALUE;
      skid_d  = BUBBLE_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (out_xfer && in_xfer) begin
            main_d = in_data;
          end else if (out_xfer) begin
            state_d = EMPTY;
            main_d  = BUBBLE_VALUE;
          end else if (in_xfer) begin
            state_d = FULL;
            skid_d  = in_data;
          end
        end
        FULL: begin
          // in_ready_q is low here, so only the drain path exists.
          if (out_xfer) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE_VALUE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE_VALUE;
          skid_d  = BUBBLE_VALUE;
        end
      endcase
    end

    // Registering the next-state view of "not full" keeps in_ready free of
    // any same-cycle dependence on out_ready.
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_q     <= BUBBLE_VALUE;
      skid_q     <= BUBBLE_VALUE;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = (state_q == EMPTY) ? BUBBLE_VALUE : main_q;
  assign count     = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for the pipe_stage_reg skid buffer.
//
// Inputs change 1 time unit after each rising edge. The scoreboard process
// looks at the stage on every falling edge: accepted payloads are queued,
// delivered payloads are popped and compared, and the queue depth is the
// expected entry count. Directed sequences add hand-computed spot checks.
module tb_pipe_stage_reg;

  localparam int          DW  = 64;
  localparam logic [63:0] BUB = 64'hDEAD_BEEF_0BAD_F00D;

  logic          clock;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [1:0]    count;

  int passCount  = 0;
  int checkCount = 0;

  logic [DW-1:0] expQ[$];
  bit            armed = 0;

  pipe_stage_reg #(
    .DATA_WIDTH  (DW),
    .BUBBLE_VALUE(BUB)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic compare(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    else
      passCount++;
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic ordy,
                               input logic fl, input logic rs);
    @(posedge clock);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
  endtask

  // Hand-computed check of the visible state at the next falling edge.
  task automatic checkOutput(input string name, input logic [1:0] cnt, input logic ir,
                             input logic ov, input logic [63:0] od);
    @(negedge clock);
    compare({name, ".count"}, {62'd0, count}, {62'd0, cnt});
    compare({name, ".in_ready"}, {63'd0, in_ready}, {63'd0, ir});
    compare({name, ".out_valid"}, {63'd0, out_valid}, {63'd0, ov});
    compare({name, ".out_data"}, out_data, od);
  endtask

  // Scoreboard: compare against the queue model, then advance the model by
  // the transfers that the upcoming rising edge will perform.
  always @(negedge clock) begin
    if (armed) begin
      compare("sb.count", {62'd0, count}, 64'(expQ.size()));
      compare("sb.in_ready", {63'd0, in_ready}, {63'd0, expQ.size() != 2});
      if (expQ.size() != 0) begin
        compare("sb.out_valid", {63'd0, out_valid}, 64'd1);
        compare("sb.out_data", out_data, expQ[0]);
      end else begin
        compare("sb.out_valid", {63'd0, out_valid}, 64'd0);
        compare("sb.bubble", out_data, BUB);
      end
    end
    if (reset) begin
      expQ.delete();
      armed = 1;
    end else if (armed) begin
      if (out_ready && expQ.size() != 0)
        void'(expQ.pop_front());
      if (flush)
        expQ.delete();
      else if (in_valid && expQ.size() < 2 && in_ready)
        expQ.push_back(in_data);
    end
  end

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset with a payload offered: it must be ignored.
    applyStimulus(1'b1, 64'h55, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset", 2'd0, 1'b1, 1'b0, BUB);

    // Streaming at full rate.
    applyStimulus(1'b1, 64'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'd2, 1'b1, 1'b0, 1'b0);
    checkOutput("stream1", 2'd1, 1'b1, 1'b1, 64'd1);
    applyStimulus(1'b1, 64'd3, 1'b1, 1'b0, 1'b0);
    checkOutput("stream2", 2'd1, 1'b1, 1'b1, 64'd2);
    applyStimulus(1'b1, 64'd4, 1'b1, 1'b0, 1'b0);
    checkOutput("stream3", 2'd1, 1'b1, 1'b1, 64'd3);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("stream4", 2'd1, 1'b1, 1'b1, 64'd4);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("streamEnd", 2'd0, 1'b1, 1'b0, BUB);

    // Stall fill, then drain in order.
    applyStimulus(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
    checkOutput("stallOne", 2'd1, 1'b1, 1'b1, 64'hA);
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("stallFull", 2'd2, 1'b0, 1'b1, 64'hA);
    #1 out_ready = 1'b1;
    #1 compare("noCombPath.in_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b0;
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("stallHold", 2'd2, 1'b0, 1'b1, 64'hA);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("drainB", 2'd1, 1'b1, 1'b1, 64'hB);
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("drainEmpty", 2'd0, 1'b1, 1'b0, BUB);

    // Flush while full with a third payload offered.
    applyStimulus(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'hC, 1'b0, 1'b1, 1'b0);
    checkOutput("preFlush", 2'd2, 1'b0, 1'b1, 64'hA);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("postFlush", 2'd0, 1'b1, 1'b0, BUB);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("noC", 2'd0, 1'b1, 1'b0, BUB);

    // Reset while full with a payload offered; the next payload is alone.
    applyStimulus(1'b1, 64'h11, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h22, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h33, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 64'h44, 1'b0, 1'b0, 1'b0);
    checkOutput("midReset", 2'd0, 1'b1, 1'b0, BUB);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("firstAfterReset", 2'd1, 1'b1, 1'b1, 64'h44);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("aloneAfterReset", 2'd0, 1'b1, 1'b0, BUB);

    // Random traffic with occasional flush and reset; scoreboard checks.
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom},
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 31) == 0),
                    1'($urandom_range(0, 255) == 0));
    end
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("finalDrain", 2'd0, 1'b1, 1'b0, BUB);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_WIDTH, default 64: width of the carried payload, for example PC plus instruction.
REQ-002 Parameter BUBBLE_VALUE, default 0: value driven on out_data whenever out_valid=0, and loaded into cleared slots.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discard all held entries at the next edge (branch or exception kill).
REQ-006 in_valid  input  1  upstream presents a valid payload.
REQ-007 in_data  input  DATA_WIDTH  upstream payload.
REQ-008 in_ready  output  1  stage can accept a payload this cycle.
REQ-009 out_valid  output  1  downstream payload is valid.
REQ-010 out_data  output  DATA_WIDTH  downstream payload.
REQ-011 out_ready  input  1  downstream accepts the payload this cycle.
REQ-012 count  output  2  number of held entries (0, 1 or 2).

Function
REQ-013 The block SHALL be a 2-entry skid buffer: a main register drives the outputs; a skid register absorbs one extra payload during a downstream stall.
REQ-014 Input transfer SHALL occur on a clock edge with in_valid=1 and in_ready=1.
- Output transfer SHALL occur on a clock edge with out_valid=1 and out_ready=1.
REQ-015 in_ready SHALL be a registered signal, equal to (count != 2), with no combinational path from out_ready.
REQ-016 out_valid SHALL equal (count != 0).
- out_data SHALL equal the main register, or BUBBLE_VALUE when count = 0.
REQ-017 The states SHALL be EMPTY, ONE and FULL, encoded as count 0, 1 and 2.
REQ-018 EMPTY transitions:
- in xfer -> ONE, main <= in_data.
- otherwise stay EMPTY.
REQ-019 ONE transitions:
- out xfer and in xfer -> ONE, main <= in_data.
- out xfer only -> EMPTY, main <= BUBBLE_VALUE.
- in xfer only -> FULL, skid <= in_data.
- neither -> hold.
REQ-020 FULL transitions:
- out xfer -> ONE, main <= skid, skid <= BUBBLE_VALUE.
- otherwise hold.
- in_ready=0 in FULL, so no input transfer SHALL occur.
REQ-021 Latency SHALL be 1 cycle from input transfer to out_valid when the stage is EMPTY.
- Sustained throughput SHALL be 1 payload per cycle while out_ready=1.
REQ-022 Order SHALL be strict FIFO: no payload is duplicated, dropped or reordered, except by flush.
REQ-023 flush=1 SHALL force count to 0 and both registers to BUBBLE_VALUE at the next edge, regardless of in_valid and out_ready.
- A payload presented in the flush cycle SHALL be discarded.
REQ-024 An output transfer that occurs in the flush cycle SHALL still count as delivered downstream.
REQ-025 reset SHALL take priority over flush, and flush SHALL take priority over all transfers.
REQ-026 out_valid SHALL never deassert without an output transfer, except on flush or reset.
- out_data SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-027 While reset=1 at an edge, the block SHALL set count=0, out_valid=0, in_ready=1, and main = skid = BUBBLE_VALUE.
REQ-028 Input transfers SHALL be ignored in the cycle reset is applied.
- After reset deasserts, operation SHALL resume from EMPTY with no stale payload.

Verification
REQ-029 Streaming: out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive edges -> out_data 1,2,3,4 one cycle later, count stays 1, in_ready stays 1.
REQ-030 Stall fill: out_ready=0, send A then B -> count=2, in_ready=0, out_data=A held. Then raise out_ready -> A, then B delivered; count goes 1 then 0.
REQ-031 Flush while FULL (A,B held) with in_valid=1 data C -> next cycle count=0, out_valid=0, out_data=BUBBLE_VALUE, C never appears.
REQ-032 Reset mid-stream with count=2 and in_valid=1 -> next cycle count=0, in_ready=1, out_valid=0. The first payload after reset emerges alone.
REQ-033 Randomized in_valid/out_ready over 10k cycles, DATA_WIDTH=8 and 64 -> output sequence equals input sequence minus flushed entries; in_ready never depends combinationally on out_ready.
